// File: rtl/floating_point_multiplier.sv
// 12-bit reduced-precision float multiplier (1/5/6, bias 15), one registered stage.
// Define FPMUL_ROUND_NEAREST_EN for round-to-nearest-even; default build truncates.
module floating_point_multiplier #(
    parameter int          BIAS    = 15,
    parameter int          MAX_EXP = 29,
    parameter logic [10:0] SAT_MAG = 11'h7B0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] a,
    input  logic [11:0] b,
    input  logic        valid_in,
    output logic [11:0] result,
    output logic        valid_out
);

    localparam logic [7:0]        BIAS_W = 8'(BIAS);
    localparam logic signed [7:0] MAX_W  = 8'(MAX_EXP);

    logic        sign;
    logic [4:0]  ea, eb;
    logic [6:0]  ma, mb;
    logic [13:0] p, p_norm;
    logic        norm;
    logic [5:0]  frac_t, frac_r;
    logic        round_up, carry;
    logic [7:0]  e_raw, e_fin;
    logic [11:0] next_result;
    logic        unused_bits;

    always_comb begin
        sign   = a[11] ^ b[11];
        ea     = a[10:6];
        eb     = b[10:6];
        ma     = {1'b1, a[5:0]};
        mb     = {1'b1, b[5:0]};
        p      = {7'b0, ma} * {7'b0, mb};
        norm   = p[13];
        // Align so the leading one always sits at bit 13; fraction is then p_norm[12:7].
        p_norm = norm ? p : {p[12:0], 1'b0};
        frac_t = p_norm[12:7];
        e_raw  = {3'b0, ea} + {3'b0, eb} + {7'b0, norm} - BIAS_W;
    end

`ifdef FPMUL_ROUND_NEAREST_EN
    assign round_up    = p_norm[6] & ((|p_norm[5:0]) | frac_t[0]);
    assign unused_bits = p_norm[13];
`else
    assign round_up    = 1'b0;
    assign unused_bits = ^{p_norm[13], p_norm[6:0]};
`endif

    always_comb begin
        {carry, frac_r} = {1'b0, frac_t} + {6'b0, round_up};
        // A carry out of the fraction leaves frac_r at zero, i.e. mantissa 1.0 at E+1.
        e_fin = e_raw + {7'b0, carry};
        if (ea == 5'd0 || eb == 5'd0) begin
            next_result = 12'h000;
        end else if ($signed(e_fin) < 8'sd1) begin
            next_result = 12'h000;
        end else if ($signed(e_fin) > MAX_W) begin
            next_result = {sign, SAT_MAG};
        end else begin
            next_result = {sign, e_fin[4:0], frac_r};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result    <= 12'h000;
            valid_out <= 1'b0;
        end else begin
            valid_out <= valid_in;
            if (valid_in) begin
                result <= next_result;
            end
        end
    end

endmodule

// File: tb/tb_floating_point_multiplier.sv
// Scoreboard bench for floating_point_multiplier: directed vectors plus random
// operands against an integer-arithmetic reference model.
module tb_floating_point_multiplier;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] a = 12'h000;
    logic [11:0] b = 12'h000;
    logic        valid_in = 1'b0;
    logic [11:0] result;
    logic        valid_out;

    int total = 0;
    int bad = 0;
    logic [11:0] exp_q[$];
    logic [11:0] last_exp = 12'h000;

    floating_point_multiplier dut (
        .clk(clk),
        .rst(rst),
        .a(a),
        .b(b),
        .valid_in(valid_in),
        .result(result),
        .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] ref_mul(input logic [11:0] x, input logic [11:0] y);
        int ex, ey, mx, my, prod, e, sh, q;
        logic s;
        s  = x[11] ^ y[11];
        ex = int'(x[10:6]);
        ey = int'(y[10:6]);
        if (ex == 0 || ey == 0) return 12'h000;
        mx   = 64 + int'(x[5:0]);
        my   = 64 + int'(y[5:0]);
        prod = mx * my;
        e    = ex + ey - 15;
        if (prod >= 8192) begin
            e++;
            sh = 7;
        end else begin
            sh = 6;
        end
        q = prod / (1 << sh);
`ifdef FPMUL_ROUND_NEAREST_EN
        begin
            int rem, half;
            rem  = prod % (1 << sh);
            half = (1 << sh) / 2;
            if (rem > half || (rem == half && (q % 2) == 1)) q++;
            if (q == 128) begin
                q = 64;
                e++;
            end
        end
`endif
        if (e < 1) return 12'h000;
        if (e > 29) return {s, 11'h7B0};
        return {s, 5'(e), 6'(q - 64)};
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %03h want %03h", name, act, req);
        end
    endtask

    task automatic issue(input logic [11:0] x, input logic [11:0] y, input logic v,
                         input logic [11:0] req);
        @(posedge clk);
        #1;
        a = x;
        b = y;
        valid_in = v;
        if (v) exp_q.push_back(req);
    endtask

    // Monitor: valid_out must echo the valid_in seen at the edge; results pop the scoreboard.
    initial begin
        logic v_cap, r_cap;
        forever begin
            @(posedge clk);
            v_cap = valid_in;
            r_cap = rst;
            #2;
            if (rst || r_cap) begin
                last_exp = 12'h000;
                if (rst) begin
                    check("reset_result", result, 12'h000);
                    check("reset_valid", {11'b0, valid_out}, 12'h000);
                end
            end else begin
                check("valid_out", {11'b0, valid_out}, {11'b0, v_cap});
                if (valid_out) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", result, 12'hFFF);
                    end else begin
                        last_exp = exp_q.pop_front();
                        check("product", result, last_exp);
                    end
                end else begin
                    check("hold", result, last_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [11:0] x, y;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        issue(12'h3C0, 12'h400, 1'b1, 12'h400);
        issue(12'h000, 12'h000, 1'b0, 12'h000);
        issue(12'h000, 12'h000, 1'b0, 12'h000);
        issue(12'h000, 12'h3E0, 1'b1, 12'h000);
        issue(12'h020, 12'h3C0, 1'b1, 12'h000);
        issue(12'h3C0, 12'hBC0, 1'b1, 12'hBC0);
        issue(12'hBC0, 12'hBC0, 1'b1, 12'h3C0);
        issue(12'h0A0, 12'h0A0, 1'b1, 12'h000);
        issue(12'h770, 12'h770, 1'b1, 12'h7B0);
        issue(12'h740, 12'h3C0, 1'b1, 12'h740);
        issue(12'h3C0, 12'h740, 1'b1, 12'h740);
        issue(12'h040, 12'h3C0, 1'b1, 12'h040);
        issue(12'h3D0, 12'h3D0, 1'b1, 12'h3E4);

        for (int i = 0; i < 8; i++) begin
            x = 12'($urandom);
            y = 12'($urandom);
            issue(x, y, 1'b0, 12'h000);
        end

        for (int i = 0; i < 400; i++) begin
            x = 12'($urandom);
            y = 12'($urandom);
            issue(x, y, ($urandom_range(0, 3) != 0), ref_mul(x, y));
        end

        // Asynchronous reset mid-stream with a non-zero result held.
        issue(12'h3D0, 12'h3D0, 1'b1, 12'h3E4);
        issue(12'h123, 12'h456, 1'b0, 12'h000);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_result", result, 12'h000);
        check("async_rst_valid", {11'b0, valid_out}, 12'h000);
        @(posedge clk);
        #4;
        rst = 1'b0;

        issue(12'hBC0, 12'h400, 1'b1, 12'hC00);
        for (int i = 0; i < 50; i++) begin
            x = 12'($urandom);
            y = 12'($urandom);
            issue(x, y, 1'b1, ref_mul(x, y));
        end
        issue(12'h000, 12'h000, 1'b0, 12'h000);
        repeat (4) @(posedge clk);
        #4;
        check("queue_drained", 12'(exp_q.size()), 12'h000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
